// File: rtl/ctrl_sequencer.sv
// Microcode control sequencer for the 8-bit CPU.
// Steps T0..LAST_STEP, decodes opcode/step/flags into the control word.
module ctrl_sequencer #(
  parameter int LAST_STEP = 4,
  parameter bit EARLY_END = 1'b1
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        CLR,
  input  logic [3:0]  OPCODE,
  input  logic        CF,
  input  logic        ZF,
  output logic [14:0] CTRL,
  output logic        FIn,
  output logic [2:0]  STEP,
  output logic        HALTED
);

  localparam logic [14:0] HLT = 15'h4000;
  localparam logic [14:0] MI  = 15'h2000;
  localparam logic [14:0] RI  = 15'h1000;
  localparam logic [14:0] RO  = 15'h0800;
  localparam logic [14:0] IO  = 15'h0400;
  localparam logic [14:0] II  = 15'h0200;
  localparam logic [14:0] AI  = 15'h0100;
  localparam logic [14:0] AO  = 15'h0080;
  localparam logic [14:0] EO  = 15'h0040;
  localparam logic [14:0] SU  = 15'h0020;
  localparam logic [14:0] BI  = 15'h0010;
  localparam logic [14:0] OI  = 15'h0008;
  localparam logic [14:0] CE  = 15'h0004;
  localparam logic [14:0] CO  = 15'h0002;
  localparam logic [14:0] J   = 15'h0001;

  localparam logic [2:0] LAST = 3'(LAST_STEP);

  logic [2:0]  step_q, step_d;
  logic        halted_q, halted_d;
  logic [14:0] word;
  logic        word_fin;
  logic        rst_act;

  assign rst_act = !RESETn || CLR;

  // Microcode decode of the current step, before halt/reset overrides.
  always_comb begin
    word     = '0;
    word_fin = 1'b1;
    if (step_q == 3'd0) begin
      word = MI | CO;
    end else if (step_q == 3'd1) begin
      word = RO | II | CE;
    end else begin
      case (OPCODE)
        4'b0001: begin
          if (step_q == 3'd2) word = IO | MI;
          if (step_q == 3'd3) word = RO | AI;
        end
        4'b0010, 4'b0011: begin
          if (step_q == 3'd2) word = IO | MI;
          if (step_q == 3'd3) word = RO | BI;
          if (step_q == 3'd4) begin
            word     = EO | AI | (OPCODE[0] ? SU : '0);
            word_fin = 1'b0;
          end
        end
        4'b0100: begin
          if (step_q == 3'd2) word = IO | MI;
          if (step_q == 3'd3) word = AO | RI;
        end
        4'b0101: if (step_q == 3'd2) word = IO | AI;
        4'b0110: if (step_q == 3'd2) word = IO | J;
        4'b0111: if (step_q == 3'd2 && CF) word = IO | J;
        4'b1000: if (step_q == 3'd2 && ZF) word = IO | J;
        4'b1110: if (step_q == 3'd2) word = AO | OI;
        4'b1111: if (step_q == 3'd2) word = HLT;
        default: word = '0;
      endcase
    end
  end

  // Output mux: reset forces the fetch word, halt forces HLT only.
  always_comb begin
    CTRL = word;
    FIn  = word_fin;
    if (rst_act) begin
      CTRL = MI | CO;
      FIn  = 1'b1;
    end else if (halted_q) begin
      CTRL = HLT;
      FIn  = 1'b1;
    end
  end

  // Next step: hold on halt, wrap at last step, or end early on empty word.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (word[14]) begin
        halted_d = 1'b1;
      end else if (step_q == LAST) begin
        step_d = 3'd0;
      end else if (EARLY_END && step_q >= 3'd2 &&
                   word == '0 && word_fin) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  // State registers with synchronous reset/clear.
  always_ff @(posedge CLK) begin
    if (rst_act) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign STEP   = step_q;
  assign HALTED = halted_q;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Microcode control sequencer for the 8-bit CPU.
- Holds the T-state step counter and decodes the 4-bit opcode and step into the control word each cycle.
- Sits directly upstream of the ALU: it drives SU and FIn, and consumes the registered CF/ZF flags for conditional jumps.
- Also drives the memory, program-counter, register and output-latch enables.

Parameters:
- LAST_STEP, 4, index of the final T-state (5-step instruction cycle, T0..T4).
- EARLY_END, 1, when 1 the step counter returns to 0 on the first step whose decoded word is all-inactive (after T1).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESETn  input  1  synchronous reset, active-low.
- CLR  input  1  synchronous clear, active-high; same effect as reset on this block.
- OPCODE  input  4  upper nibble of the instruction register.
- CF  input  1  registered carry flag from the ALU.
- ZF  input  1  registered zero flag from the ALU.
- CTRL  output  15  active-high control bits, combinational from step, opcode and flags. Bit map: [14]HLT [13]MI [12]RI [11]RO [10]IO [9]II [8]AI [7]AO [6]EO [5]SU [4]BI [3]OI [2]CE [1]CO [0]J.
- FIn  output  1  ALU flag-load enable, active-low; 1 = hold flags.
- STEP  output  3  current T-state.
- HALTED  output  1  halt latch.

Behaviour:
- Reset / CLR (synchronous, either RESETn=0 or CLR=1): STEP=0, HALTED=0. Reset wins over every other event in the same cycle.
- Output values while reset/CLR is held, and at T0 after reset: CTRL={MI,CO}=0x2002, FIn=1.
- Fetch, all opcodes:
  - T0: CO|MI.
  - T1: RO|II|CE.
- Execute, T2..T4, opcode (value) -> active bits per step; unlisted steps are all-inactive:
  - NOP 0000: none.
  - LDA 0001: T2 IO|MI; T3 RO|AI.
  - ADD 0010: T2 IO|MI; T3 RO|BI; T4 EO|AI, FIn=0.
  - SUB 0011: T2 IO|MI; T3 RO|BI; T4 EO|AI|SU, FIn=0.
  - STA 0100: T2 IO|MI; T3 AO|RI.
  - LDI 0101: T2 IO|AI.
  - JMP 0110: T2 IO|J.
  - JC 0111: T2 IO|J only if CF=1, otherwise none.
  - JZ 1000: T2 IO|J only if ZF=1, otherwise none.
  - OUT 1110: T2 AO|OI.
  - HLT 1111: T2 HLT.
  - Opcodes 1001–1101: decode as NOP.
- FIn=1 in every step not listed above; SU=1 only at SUB T4.
- Flag use: CF/ZF are sampled combinationally during T2. Because the flags are registered, a jump sees the flags from the most recent ADD/SUB.
- Step advance:
  - STEP increments by 1 each cycle.
  - STEP wraps LAST_STEP -> 0.
  - With EARLY_END=1: if STEP>=2 and the decoded CTRL is all-zero with FIn=1, STEP goes to 0 on the next edge instead of incrementing. That step still occupies one cycle. Example: a JC not taken completes in 3 cycles; LDA completes in 5 cycles.
- Halt:
  - At HLT T2 the HLT bit asserts and HALTED sets on the next edge.
  - While HALTED=1: STEP frozen, CTRL=HLT only (0x4000), FIn=1.
  - Only reset or CLR leaves the halted state.
- Simultaneous events: CLR during any step, including mid-instruction or while halted, forces STEP=0 and HALTED=0 next cycle. No partial instruction effects persist in this block.
- No X on outputs for any OPCODE/flag input once reset has been applied.

Test Plan:
- Reset/fetch: hold RESETn=0 for 2 cycles, release with OPCODE=0000.
  -> STEP=0 and CTRL=0x2002; next cycle STEP=1, CTRL=0x0A04 (RO|II|CE); STEP returns to 0 on the 3rd cycle (EARLY_END=1).
- SUB sequence: OPCODE=0011.
  -> At T4, CTRL=0x0160 (AI|EO|SU) and FIn=0; then STEP wraps to 0.
  -> Same with ADD: CTRL=0x0140, FIn=0.
- Conditional jumps, OPCODE=0111:
  - CF=1 -> T2 CTRL=0x0401 (IO|J).
  - CF=0 -> T2 CTRL=0x0000 and STEP=0 on the next edge.
  - Repeat with JZ and ZF.
- Halt: OPCODE=1111 through T2.
  -> HALTED=1 after the edge; STEP stays 2 for 10 cycles; CTRL=0x4000.
  -> Assert CLR -> STEP=0, HALTED=0.
- Mid-instruction clear: assert CLR at LDA T3.
  -> Next cycle STEP=0, CTRL=0x2002.
  -> Same with RESETn=0 and CLR=1 together.
- Undefined opcodes: sweep 1001–1101 and EARLY_END=0.
  -> T2..T4 all inactive, FIn=1, every instruction takes exactly 5 cycles.
